// File: rtl/game_sequencer.sv
// game_sequencer
// Rally controller for the Pong datapath. Walks the ball-movement block
// through idle, serve, play and scoring phases, commands a centred ball load
// with pseudo-random serve parameters on every serve, gates ball motion per
// frame, detects edge misses, keeps both scores and declares the winner.
//
// Ports
//   clk                 system clock, all state changes on the rising edge
//   rst_n               asynchronous active-low reset
//   frame_tick_i        one-cycle pulse per video frame
//   start_i             start request, honoured in IDLE and OVER only
//   pause_i             level; freezes serve countdown and ball motion
//   ball_x_i            current ball x coordinate
//   paddle_collision_i  paddle hit this frame
//   ball_load_o         one-cycle command: ball to centre, load serve params
//   serve_dir_x_o       1 = serve rightward
//   serve_dir_y_o       1 = serve downward
//   serve_vel_y_o       vertical serve speed, 1..3
//   ball_run_o          ball-movement enable
//   score_l_o/score_r_o player scores
//   game_over_o         high while the game is over
//   winner_o            0 = left, 1 = right; valid while game_over_o
//   state_o             current state encoding (debug)
module game_sequencer #(
    parameter int         FIELD_W     = 64,
    parameter int         SCORE_MAX   = 7,
    parameter int         SERVE_DELAY = 60,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    localparam int        CW          = $clog2(FIELD_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick_i,
    input  logic          start_i,
    input  logic          pause_i,
    input  logic [CW-1:0] ball_x_i,
    input  logic          paddle_collision_i,
    output logic          ball_load_o,
    output logic          serve_dir_x_o,
    output logic          serve_dir_y_o,
    output logic [1:0]    serve_vel_y_o,
    output logic          ball_run_o,
    output logic [3:0]    score_l_o,
    output logic [3:0]    score_r_o,
    output logic          game_over_o,
    output logic          winner_o,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        SERVE_WAIT = 3'd2,
        PLAY       = 3'd3,
        POINT      = 3'd4,
        OVER       = 3'd5
    } state_t;

    localparam logic [7:0]    DELAY_LAST = 8'(SERVE_DELAY - 1);
    localparam logic [3:0]    SCORE_WIN  = 4'(SCORE_MAX);
    localparam logic [CW-1:0] X_RIGHT    = CW'(FIELD_W - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       dir_x_q;
    logic       dir_y_q;
    logic [1:0] vel_q;
    logic [3:0] score_l_q;
    logic [3:0] score_r_q;
    logic       winner_q;
    logic       right_scored_q;
    logic       ball_load_q;
    logic       game_over_q;
    logic       play_tick;
    logic [1:0] vel_draw;
    logic [3:0] score_l_inc;
    logic [3:0] score_r_inc;

    // Fibonacci LFSR, taps 8,6,5,4; free-running so serves stay unpredictable
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // A zero vertical speed would make the ball bounce horizontally forever
    assign vel_draw    = (lfsr_q[1:0] == 2'd0) ? 2'd1 : lfsr_q[1:0];
    assign play_tick   = frame_tick_i & ~pause_i;
    assign score_l_inc = score_l_q + 4'd1;
    assign score_r_inc = score_r_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            dir_x_q        <= 1'b0;
            dir_y_q        <= 1'b0;
            vel_q          <= 2'd1;
            score_l_q      <= 4'd0;
            score_r_q      <= 4'd0;
            winner_q       <= 1'b0;
            right_scored_q <= 1'b0;
            ball_load_q    <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            ball_load_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= LOAD;
                        ball_load_q <= 1'b1;
                        dir_x_q     <= lfsr_q[3];
                        dir_y_q     <= lfsr_q[2];
                        vel_q       <= vel_draw;
                    end
                end
                LOAD: begin
                    state_q <= SERVE_WAIT;
                    cnt_q   <= 8'd0;
                end
                SERVE_WAIT: begin
                    if (play_tick) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == DELAY_LAST) begin
                            state_q <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    // A paddle hit on the edge frame is a return, not a miss
                    if (play_tick && !paddle_collision_i) begin
                        if (ball_x_i == '0) begin
                            right_scored_q <= 1'b1;
                            state_q        <= POINT;
                        end else if (ball_x_i == X_RIGHT) begin
                            right_scored_q <= 1'b0;
                            state_q        <= POINT;
                        end
                    end
                end
                POINT: begin
                    if (right_scored_q) begin
                        score_r_q <= score_r_inc;
                    end else begin
                        score_l_q <= score_l_inc;
                    end
                    if ((right_scored_q ? score_r_inc : score_l_inc) == SCORE_WIN) begin
                        state_q     <= OVER;
                        winner_q    <= right_scored_q;
                        game_over_q <= 1'b1;
                    end else begin
                        // Next serve heads toward the player who conceded
                        state_q     <= LOAD;
                        ball_load_q <= 1'b1;
                        dir_x_q     <= ~right_scored_q;
                        dir_y_q     <= lfsr_q[2];
                        vel_q       <= vel_draw;
                    end
                end
                OVER: begin
                    if (start_i) begin
                        state_q     <= LOAD;
                        ball_load_q <= 1'b1;
                        game_over_q <= 1'b0;
                        score_l_q   <= 4'd0;
                        score_r_q   <= 4'd0;
                        dir_x_q     <= lfsr_q[3];
                        dir_y_q     <= lfsr_q[2];
                        vel_q       <= vel_draw;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ball_load_o   = ball_load_q;
    assign serve_dir_x_o = dir_x_q;
    assign serve_dir_y_o = dir_y_q;
    assign serve_vel_y_o = vel_q;
    // Motion enable follows pause immediately so the ball freezes the same cycle
    assign ball_run_o    = (state_q == PLAY) & ~pause_i;
    assign score_l_o     = score_l_q;
    assign score_r_o     = score_r_q;
    assign game_over_o   = game_over_q;
    assign winner_o      = winner_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

    localparam int         FW   = 64;
    localparam int         SM   = 7;
    localparam int         SD   = 3;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       col = 1'b0;
    logic [5:0] bx = 6'd31;
    logic       ball_load, dir_x, dir_y, ball_run, game_over, winner;
    logic [1:0] vel;
    logic [3:0] score_l, score_r;
    logic [2:0] state;

    game_sequencer #(
        .FIELD_W(FW), .SCORE_MAX(SM), .SERVE_DELAY(SD), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick_i(frame_tick), .start_i(start),
        .pause_i(pause), .ball_x_i(bx), .paddle_collision_i(col),
        .ball_load_o(ball_load), .serve_dir_x_o(dir_x), .serve_dir_y_o(dir_y),
        .serve_vel_y_o(vel), .ball_run_o(ball_run), .score_l_o(score_l),
        .score_r_o(score_r), .game_over_o(game_over), .winner_o(winner),
        .state_o(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Serve LFSR reference: 8-bit Fibonacci, taps 8,6,5,4, one step per clock
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // Behavioural game model: phase number, unpaused serve ticks, scores
    int m_phase, m_ticks, m_sl, m_sr, m_vel;
    bit m_dx, m_dy, m_load, m_over, m_win, m_right;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ticks = 0; m_sl = 0; m_sr = 0; m_vel = 1;
        m_dx = 0; m_dy = 0; m_load = 0; m_over = 0; m_win = 0; m_right = 0;
    endtask

    task automatic serve(input logic [7:0] lf, input bit dx);
        m_dx = dx;
        m_dy = lf[2];
        m_vel = (lf % 4 == 0) ? 1 : int'(lf % 4);
        m_load = 1;
        m_phase = 1;
    endtask

    task automatic model_step(input logic [7:0] lf, input bit tk, st, ps, cl, input int x);
        m_load = 0;
        case (m_phase)
            0: if (st) serve(lf, lf[3]);
            1: begin m_phase = 2; m_ticks = 0; end
            2: if (tk && !ps) begin
                m_ticks++;
                if (m_ticks == SD) m_phase = 3;
            end
            3: if (tk && !ps && !cl && (x == 0 || x == FW - 1)) begin
                m_right = (x == 0);
                m_phase = 4;
            end
            4: begin
                if (m_right) m_sr++; else m_sl++;
                if ((m_right ? m_sr : m_sl) == SM) begin
                    m_over = 1; m_win = m_right; m_phase = 5;
                end else begin
                    serve(lf, !m_right);
                end
            end
            5: if (st) begin
                m_sl = 0; m_sr = 0; m_over = 0;
                serve(lf, lf[3]);
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string name);
        logic [18:0] act, exp;
        bit m_run;
        m_run = (m_phase == 3) && !pause;
        act = {state, ball_load, ball_run, dir_x, dir_y, vel, score_l, score_r, game_over, winner};
        exp = {3'(m_phase), m_load, m_run, m_dx, m_dy, 2'(m_vel), 4'(m_sl), 4'(m_sr), m_over, m_win};
        chk(name, int'(act), int'(exp));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare
    task automatic run_cycle(input bit tk, st, ps, cl, input int x);
        logic [7:0] lf;
        frame_tick = tk; start = st; pause = ps; col = cl; bx = 6'(x);
        lf = m_lfsr;
        @(negedge clk);
        model_step(lf, tk, st, ps, cl, x);
        check_all("cycle outputs");
    endtask

    task automatic to_play();
        int g = 0;
        while (m_phase != 3 && g < 100) begin
            run_cycle(1, 0, 0, 0, 31);
            g++;
        end
        if (m_phase != 3) chk("to_play timeout", int'(state), 3);
    endtask

    task automatic miss_left();
        to_play();
        run_cycle(1, 0, 0, 0, FW - 1);
        run_cycle(0, 0, 0, 0, 31);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        frame_tick = 0; start = 0; pause = 0; col = 0; bx = 6'd31;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit tk;
        bit ps;
        bit cl;
        int x;
        int exp_state;
        int exp_dx;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int serves, vel0, dy0, dy1, cyc, games, g;
        bit tk, st, ps, cl;
        int sel, x;

        tbl[0] = '{1, 0, 0, 0,  4, 0};
        tbl[1] = '{1, 0, 1, 0,  3, 0};
        tbl[2] = '{1, 1, 0, 63, 3, 0};
        tbl[3] = '{0, 0, 0, 63, 3, 0};
        tbl[4] = '{1, 0, 0, 63, 4, 1};
        tbl[5] = '{1, 0, 1, 63, 3, 0};
        tbl[6] = '{1, 0, 0, 31, 3, 0};
        tbl[7] = '{1, 0, 0, 1,  3, 0};
        tbl[8] = '{1, 0, 0, 62, 3, 0};
        tbl[9] = '{1, 0, 0, 0,  4, 0};

        // Reset values
        @(negedge clk);
        reset_dut();
        check_all("reset outputs");
        chk("reset state", int'(state), 0);
        chk("reset serve_vel_y", int'(vel), 1);
        $display("reset: state=%0d vel=%0d", state, vel);

        // Start pulse -> one-cycle ball_load, then SERVE_WAIT
        run_cycle(0, 1, 0, 0, 31);
        chk("start ball_load", int'(ball_load), 1);
        chk("start state", int'(state), 1);
        chk("start vel range", int'(vel != 2'd0), 1);
        run_cycle(0, 0, 0, 0, 31);
        chk("ball_load one cycle", int'(ball_load), 0);
        chk("serve_wait state", int'(state), 2);
        $display("start: serve dx=%0d dy=%0d vel=%0d", dir_x, dir_y, vel);

        // Serve countdown with a paused tick in the middle
        run_cycle(1, 0, 0, 0, 31);
        run_cycle(1, 0, 0, 0, 31);
        run_cycle(1, 0, 1, 0, 31);
        chk("paused tick ignored", int'(state), 2);
        run_cycle(0, 0, 0, 0, 31);
        chk("no run before 3rd tick", int'(ball_run), 0);
        run_cycle(1, 0, 0, 0, 31);
        chk("play after 3rd tick", int'(state), 3);
        chk("ball_run after 3rd tick", int'(ball_run), 1);
        pause = 1'b1; #1;
        chk("pause drops ball_run", int'(ball_run), 0);
        pause = 1'b0; #1;
        chk("unpause raises ball_run", int'(ball_run), 1);
        $display("serve delay: ball_run=%0d state=%0d", ball_run, state);

        // start during PLAY is ignored
        run_cycle(0, 1, 0, 0, 31);
        chk("start ignored in play", int'(state), 3);
        chk("no load in play", int'(ball_load), 0);

        // Edge vectors applied from PLAY
        foreach (tbl[i]) begin
            to_play();
            run_cycle(tbl[i].tk, 0, tbl[i].ps, tbl[i].cl, tbl[i].x);
            chk("vector state", int'(state), tbl[i].exp_state);
            if (tbl[i].exp_state == 4) begin
                run_cycle(0, 0, 0, 0, 31);
                chk("vector reload", int'(state), 1);
                chk("vector serve_dir_x", int'(dir_x), tbl[i].exp_dx);
            end
            $display("vector %0d: x=%0d tick=%0d pause=%0d col=%0d -> state=%0d L=%0d R=%0d",
                     i, tbl[i].x, tbl[i].tk, tbl[i].ps, tbl[i].cl, state, score_l, score_r);
        end
        chk("table score_r", int'(score_r), 2);
        chk("table score_l", int'(score_l), 1);

        // Left wins by misses on the right edge
        g = 0;
        while (!m_over && g < 10) begin
            miss_left();
            g++;
        end
        chk("left reaches max", int'(score_l), 7);
        chk("game_over set", int'(game_over), 1);
        chk("winner left", int'(winner), 0);
        $display("game over: L=%0d R=%0d winner=%0d", score_l, score_r, winner);

        // Restart from OVER
        run_cycle(0, 1, 0, 0, 31);
        chk("restart load", int'(ball_load), 1);
        chk("restart score_l", int'(score_l), 0);
        chk("restart score_r", int'(score_r), 0);
        chk("restart game_over", int'(game_over), 0);
        $display("restart: state=%0d load=%0d", state, ball_load);

        // Asynchronous reset in the middle of a rally
        repeat (3) miss_left();
        run_cycle(1, 1, 0, 0, 31);
        to_play();
        chk("pre-reset score_l", int'(score_l), 3);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async reset outputs");
        chk("async reset score_l", int'(score_l), 0);
        chk("async reset state", int'(state), 0);
        $display("async reset: state=%0d score_l=%0d run=%0d", state, score_l, ball_run);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised play against the model, counting serves
        serves = 0; vel0 = 0; dy0 = 0; dy1 = 0; cyc = 0; games = 0;
        while (serves < 1000 && cyc < 60000) begin
            tk = 1'($urandom_range(0, 1));
            ps = ($urandom_range(0, 7) == 0);
            cl = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 7) == 0);
            sel = int'($urandom_range(0, 2));
            x = (sel == 0) ? 0 : (sel == 1) ? FW - 1 : int'($urandom_range(0, FW - 1));
            g = m_phase;
            run_cycle(tk, st, ps, cl, x);
            if (ball_load) begin
                serves++;
                if (vel == 2'd0) vel0++;
                if (dir_y) dy1++; else dy0++;
            end
            if (m_phase == 5 && g != 5) begin
                games++;
                $display("random game %0d: L=%0d R=%0d winner=%0d", games, score_l, score_r, winner);
            end
            cyc++;
        end
        chk("1000 serves reached", int'(serves >= 1000), 1);
        chk("serve_vel_y never 0", vel0, 0);
        chk("serve_dir_y 0 seen", int'(dy0 > 0), 1);
        chk("serve_dir_y 1 seen", int'(dy1 > 0), 1);
        $display("random: %0d serves, dy0=%0d dy1=%0d, %0d cycles", serves, dy0, dy1, cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level rally controller for the Pong datapath. Sequences the ball-movement block through idle, serve, play and scoring phases. On each serve it commands a ball load at field center with pseudo-random serve parameters, and gates ball motion on a per-frame basis. It also detects misses at the field edges, keeps both players' scores and declares a winner. It sits between the frame timing generator and the ball-movement/collision logic.

## Interface
- FIELD_W, 64, field width in pixels; coordinate width CW = clog2(FIELD_W)
- SCORE_MAX, 7, points to win (1..15)
- SERVE_DELAY, 60, frame ticks between ball load and motion start (1..255)
- LFSR_SEED, 8'hA5, nonzero reset value of the serve LFSR
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse, once per video frame
- start  in  1  one-cycle start request, honoured only in IDLE and OVER
- pause  in  1  level; freezes serve countdown and ball motion while high
- ball_x  in  CW  current ball x coordinate from ball-movement block
- paddle_collision  in  1  paddle hit this frame, from collision logic
- ball_load  out  1  one-cycle command: ball to center (31,31 for 64) and load serve parameters
- serve_dir_x  out  1  1 = serve rightward, 0 = leftward
- serve_dir_y  out  1  1 = downward, 0 = upward
- serve_vel_y  out  2  vertical serve speed, 1..3 (never 0)
- ball_run  out  1  ball-movement enable
- score_l, score_r  out  4 each  player scores
- game_over  out  1  high in OVER
- winner  out  1  0 = left, 1 = right; valid while game_over
- state  out  3  current state encoding (debug)

## Operation
- States (encoding): IDLE=0, LOAD=1, SERVE_WAIT=2, PLAY=3, POINT=4, OVER=5. Moore outputs from the state register, except ball_run.
- IDLE: start -> LOAD; first serve_dir_x = lfsr[3].
- LOAD: ball_load=1 for exactly one cycle. serve_dir_y and serve_vel_y are captured on entry and held until the next LOAD. Next state is SERVE_WAIT.
- serve_vel_y = lfsr[1:0], with 0 mapped to 1. serve_dir_y = lfsr[2].
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk, including during pause.
- SERVE_WAIT: an 8-bit counter is cleared on entry and increments on frame_tick & ~pause. A tick that finds the counter at SERVE_DELAY-1 moves the FSM to PLAY.
- PLAY: ball_run = (state==PLAY) & ~pause, combinational on pause. Edge checks happen only on frame_tick & ~pause:
  - ball_x==0 & ~paddle_collision -> right scores.
  - ball_x==FIELD_W-1 & ~paddle_collision -> left scores.
  - paddle_collision always wins over a miss.
  - The scoring side is registered and the FSM moves to POINT.
- POINT: the scorer's score is incremented. If the new value == SCORE_MAX -> OVER with winner = scorer. Otherwise -> LOAD with serve_dir_x pointing toward the player who conceded: right scored -> 0, left scored -> 1.
- OVER: game_over=1; scores and winner hold. start clears both scores, draws serve_dir_x from lfsr[3] and goes to LOAD.
- start outside IDLE/OVER is ignored. pause in IDLE/LOAD/POINT/OVER has no effect.

## Timing
- Reset values:
  - state=IDLE, counter=0, lfsr=LFSR_SEED.
  - ball_load=0, ball_run=0, serve_dir_x=0, serve_dir_y=0, serve_vel_y=1.
  - score_l=score_r=0, game_over=0, winner=0.
- Reset mid-game aborts immediately to these values, including a reset asserted in POINT before the increment.
- start sampled at edge N -> ball_load high during cycle N+1.
- ball_run first goes high in the cycle after the SERVE_DELAY-th unpaused frame_tick following LOAD.
- Miss tick at edge M -> POINT in cycle M+1 -> score visible and LOAD or OVER in cycle M+2.
- ball_run drops in the cycle after a miss tick.

## Test plan
- Reset, start pulse -> ball_load one cycle high at the next cycle; serve_vel_y in {1,2,3}; state sequence 0->1->2.
- SERVE_DELAY=3: ticks 1,2, then pause high across a tick, then tick 3 -> ball_run asserts only after the third unpaused tick, one cycle later.
- PLAY, ball_x=0 with frame_tick and paddle_collision=0 -> score_r=1, LOAD, serve_dir_x=0. Repeat with paddle_collision=1 -> no score, stays PLAY.
- ball_x=63 misses ×7 -> score_l=7, game_over=1, winner=0; start in OVER -> scores 0, ball_load pulse.
- start pulses during PLAY and SERVE_WAIT -> ignored. reset low mid-PLAY with score_l=3 -> all outputs at reset values asynchronously.
- 1000 serves -> serve_vel_y never 0; both serve_dir_y values occur.
